// File: rtl/pico_io_responder.sv
// pico_io_responder: port-mapped peripheral on the KCPSM6 I/O bus.
// Holds two output registers (out_a, out_b), a receive FIFO filled from
// fabric logic, a control/status pair and a level interrupt (ie & !empty).
// Optional build macro: PICO_IO_TIMER_EN adds a free-running 16-bit cycle
// counter readable on port 0x05 (low byte) with a high-byte snapshot on 0x06.
module pico_io_responder #(
   parameter int FIFO_DEPTH = 16
) (
   input  logic       clk,
   input  logic       cpu_reset,
   input  logic [7:0] port_id,
   input  logic [7:0] out_port,
   input  logic       write_strobe,
   input  logic       k_write_strobe,
   input  logic       read_strobe,
   output logic [7:0] in_port,
   output logic       interrupt,
   output logic [7:0] out_a,
   output logic [7:0] out_b,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       rx_ready
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
   logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
   logic [CW-1:0] count_reg, count_next;
   logic          ie_reg, ie_next;
   logic          ovf_reg, ovf_next;
   logic          irq_reg;
   logic [7:0]    out_a_reg, out_a_next;
   logic [7:0]    out_b_reg, out_b_next;
   logic [7:0]    in_port_reg, rd_data_next;

   logic          empty, full;
   logic          ctrl_wr, flush, ovf_clr, ovf_set;
   logic          do_push, do_pop;
   logic          a_wr, b_wr;
   logic [7:0]    timer_lo, timer_snap;
   logic          unused_ctrl_bits;

   assign empty    = (count_reg == '0);
   assign full     = (count_reg == FULL_COUNT);
   assign rx_ready = !full;

   // The control register only defines bits [2:0]; the rest are don't-care.
   assign unused_ctrl_bits = ^out_port[7:3];

`ifdef PICO_IO_TIMER_EN
   logic [15:0] timer_reg;
   logic [7:0]  snap_reg;

   // Free-running cycle counter; reading the low byte captures the high byte.
   always_ff @(posedge clk) begin
      if (cpu_reset) begin
         timer_reg <= '0;
         snap_reg  <= '0;
      end else begin
         timer_reg <= timer_reg + 16'd1;
         if (read_strobe && (port_id == 8'h05)) begin
            snap_reg <= timer_reg[15:8];
         end
      end
   end

   assign timer_lo   = timer_reg[7:0];
   assign timer_snap = snap_reg;
`else
   assign timer_lo   = 8'h00;
   assign timer_snap = 8'h00;
`endif

   // Bus decode and next-state computation for registers, FIFO and flags.
   always_comb begin
      ctrl_wr = write_strobe && (port_id == 8'h04);
      flush   = ctrl_wr && out_port[1];
      ovf_clr = ctrl_wr && out_port[0];
      // A flush drops any same-cycle push without counting it as overflow.
      ovf_set = rx_valid && full && !flush;
      do_push = rx_valid && !full && !flush;
      do_pop  = read_strobe && (port_id == 8'h03) && !empty && !flush;

      // write_strobe takes priority; OUTPUTK only sees the low nibble.
      if (write_strobe) begin
         a_wr = (port_id == 8'h00);
         b_wr = (port_id == 8'h01);
      end else begin
         a_wr = k_write_strobe && (port_id[3:0] == 4'h0);
         b_wr = k_write_strobe && (port_id[3:0] == 4'h1);
      end

      out_a_next = a_wr ? out_port : out_a_reg;
      out_b_next = b_wr ? out_port : out_b_reg;
      ie_next    = ctrl_wr ? out_port[2] : ie_reg;

      // A new overflow event in the same cycle as a clear is kept.
      ovf_next = ovf_reg;
      if (ovf_clr) ovf_next = 1'b0;
      if (ovf_set) ovf_next = 1'b1;

      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (flush) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         count_next  = '0;
      end else begin
         if (do_push) wr_ptr_next = wr_ptr_reg + AW'(1);
         if (do_pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
         endcase
      end

      // Read mux uses the state before this edge's update.
      case (port_id)
         8'h00:   rd_data_next = out_a_reg;
         8'h01:   rd_data_next = out_b_reg;
         8'h02:   rd_data_next = {3'b000, ie_reg, ovf_reg, full, !empty, 1'b1};
         8'h03:   rd_data_next = empty ? 8'h00 : mem[rd_ptr_reg];
         8'h05:   rd_data_next = timer_lo;
         8'h06:   rd_data_next = timer_snap;
         default: rd_data_next = 8'h00;
      endcase
   end

   // FIFO storage: write-only port here, read through the in_port register.
   always_ff @(posedge clk) begin
      if (do_push && !cpu_reset) begin
         mem[wr_ptr_reg] <= rx_data;
      end
   end

   // Architectural state, read-data register and registered interrupt.
   always_ff @(posedge clk) begin
      if (cpu_reset) begin
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         count_reg   <= '0;
         ie_reg      <= 1'b0;
         ovf_reg     <= 1'b0;
         irq_reg     <= 1'b0;
         out_a_reg   <= 8'h00;
         out_b_reg   <= 8'h00;
         in_port_reg <= 8'h00;
      end else begin
         wr_ptr_reg  <= wr_ptr_next;
         rd_ptr_reg  <= rd_ptr_next;
         count_reg   <= count_next;
         ie_reg      <= ie_next;
         ovf_reg     <= ovf_next;
         irq_reg     <= ie_next && (count_next != '0);
         out_a_reg   <= out_a_next;
         out_b_reg   <= out_b_next;
         in_port_reg <= rd_data_next;
      end
   end

   assign in_port   = in_port_reg;
   assign interrupt = irq_reg;
   assign out_a     = out_a_reg;
   assign out_b     = out_b_reg;

endmodule

// File: tb/tb_pico_io_responder.sv
// tb_pico_io_responder: directed scenarios plus randomized bus/FIFO traffic,
// checked against a queue-based behavioural model of the peripheral.
module tb_pico_io_responder;
   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       cpu_reset = 1'b1;
   logic [7:0] port_id = 8'h00;
   logic [7:0] out_port = 8'h00;
   logic       write_strobe = 1'b0;
   logic       k_write_strobe = 1'b0;
   logic       read_strobe = 1'b0;
   logic [7:0] in_port;
   logic       interrupt;
   logic [7:0] out_a;
   logic [7:0] out_b;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       rx_ready;

   pico_io_responder #(.FIFO_DEPTH(DEPTH)) dut (
      .clk            (clk),
      .cpu_reset      (cpu_reset),
      .port_id        (port_id),
      .out_port       (out_port),
      .write_strobe   (write_strobe),
      .k_write_strobe (k_write_strobe),
      .read_strobe    (read_strobe),
      .in_port        (in_port),
      .interrupt      (interrupt),
      .out_a          (out_a),
      .out_b          (out_b),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .rx_ready       (rx_ready)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   logic [7:0]  q[$];
   logic [7:0]  m_a, m_b, m_in, m_snap;
   logic        m_ie, m_ovf, m_irq;
   logic [15:0] m_t;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] model_read(input logic [7:0] pid);
      logic [7:0] v;
      case (pid)
         8'h00: v = m_a;
         8'h01: v = m_b;
         8'h02: v = {3'b000, m_ie, m_ovf, (q.size() == DEPTH), (q.size() != 0), 1'b1};
         8'h03: v = (q.size() != 0) ? q[0] : 8'h00;
`ifdef PICO_IO_TIMER_EN
         8'h05: v = m_t[7:0];
         8'h06: v = m_snap;
`endif
         default: v = 8'h00;
      endcase
      return v;
   endfunction

   task automatic do_reset();
      // Strobes and a push held during reset must all be discarded.
      cpu_reset = 1'b1; write_strobe = 1'b1; port_id = 8'h00; out_port = 8'hFF;
      k_write_strobe = 1'b0; read_strobe = 1'b0; rx_valid = 1'b1; rx_data = 8'h55;
      repeat (2) @(posedge clk);
      #1;
      cpu_reset = 1'b0; write_strobe = 1'b0; rx_valid = 1'b0;
      q.delete();
      m_a = 8'h00; m_b = 8'h00; m_in = 8'h00; m_snap = 8'h00;
      m_ie = 1'b0; m_ovf = 1'b0; m_irq = 1'b0; m_t = 16'h0000;
      check("rst_in_port", in_port, 8'h00);
      check("rst_out_a", out_a, 8'h00);
      check("rst_out_b", out_b, 8'h00);
      check("rst_interrupt", interrupt, 1'b0);
      check("rst_rx_ready", rx_ready, 1'b1);
      $display("reset done");
   endtask

   task automatic step(input logic [7:0] pid, input logic [7:0] op, input logic ws,
                       input logic kws, input logic rs, input logic rxv, input logic [7:0] rxd);
      logic [7:0] nxt_in;
      logic       was_full, fl;
      port_id = pid; out_port = op; write_strobe = ws; k_write_strobe = kws;
      read_strobe = rs; rx_valid = rxv; rx_data = rxd;
      @(posedge clk);
      nxt_in = model_read(pid);
      if (rs && pid == 8'h05) m_snap = m_t[15:8];
      m_t = m_t + 16'd1;
      fl = ws && (pid == 8'h04) && op[1];
      was_full = (q.size() == DEPTH);
      if (ws) begin
         if (pid == 8'h00) m_a = op;
         if (pid == 8'h01) m_b = op;
         if (pid == 8'h04) begin
            m_ie = op[2];
            if (op[0]) m_ovf = 1'b0;
         end
      end else if (kws) begin
         if (pid[3:0] == 4'h0) m_a = op;
         if (pid[3:0] == 4'h1) m_b = op;
      end
      if (fl) begin
         q.delete();
      end else begin
         if (rs && pid == 8'h03 && q.size() != 0) void'(q.pop_front());
         if (rxv) begin
            if (was_full) m_ovf = 1'b1;
            else q.push_back(rxd);
         end
      end
      m_in  = nxt_in;
      m_irq = m_ie && (q.size() != 0);
      #1;
      $display("txn pid=%02h op=%02h ws=%0b kws=%0b rs=%0b rxv=%0b rxd=%02h -> in_port=%02h a=%02h b=%02h irq=%0b rdy=%0b",
               pid, op, ws, kws, rs, rxv, rxd, in_port, out_a, out_b, interrupt, rx_ready);
      check("in_port", in_port, m_in);
      check("out_a", out_a, m_a);
      check("out_b", out_b, m_b);
      check("interrupt", interrupt, m_irq);
      check("rx_ready", rx_ready, (q.size() != DEPTH));
      write_strobe = 1'b0; k_write_strobe = 1'b0; read_strobe = 1'b0; rx_valid = 1'b0;
   endtask

   initial begin
      do_reset();

      // Every readable port after reset
      for (int p = 0; p <= 6; p++) begin
         step(8'(p), 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
         check("rst_port_read", in_port, (p == 2) ? 8'h01 : 8'h00);
      end

      // OUTPUT / OUTPUTK and readback
      step(8'h00, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      step(8'h11, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      check("out_a_wr", out_a, 8'hA5);
      check("out_b_wrk", out_b, 8'h3C);
      step(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      check("rd_out_a", in_port, 8'hA5);
      step(8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      check("rd_out_b", in_port, 8'h3C);
      // OUTPUT to a non-decoded port with OUTPUTK also high: nothing changes
      step(8'h10, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      check("ws_wins_a", out_a, 8'hA5);
      // OUTPUTK ignores the high nibble
      step(8'h30, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      check("k_low_nibble", out_a, 8'h5A);

      // Interrupt with two pushes and two pops
      step(8'h04, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      step(8'h07, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11);
      check("irq_after_push", interrupt, 1'b1);
      step(8'h07, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22);
      step(8'h03, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      check("pop_first", in_port, 8'h11);
      check("irq_one_left", interrupt, 1'b1);
      step(8'h03, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      check("pop_second", in_port, 8'h22);
      check("irq_after_last_pop", interrupt, 1'b0);
      step(8'h03, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      check("pop_empty", in_port, 8'h00);

      // Fill to full and overflow with ie cleared
      step(8'h04, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 17; i++) begin
         step(8'h07, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'(8'h40 + i));
         if (i == 14) check("ready_at_15", rx_ready, 1'b1);
         if (i == 15) check("ready_at_16", rx_ready, 1'b0);
      end
      step(8'h02, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      check("status_full_ovf", in_port, 8'h0F);
      step(8'h03, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hEE);
      check("pop_full_head", in_port, 8'h40);
      check("ready_after_pop", rx_ready, 1'b1);
      step(8'h07, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hEF);
      check("refull", rx_ready, 1'b0);
      step(8'h04, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      step(8'h02, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      check("status_ovf_clr", in_port, 8'h07);

      // Flush while full with a simultaneous push
      step(8'h04, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1, 8'h99);
      check("flush_ready", rx_ready, 1'b1);
      step(8'h02, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      check("status_flush", in_port, 8'h01);

      // Timer low byte / snapshot
      do_reset();
      while (m_t != 16'h0123) step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      step(8'h05, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
`ifdef PICO_IO_TIMER_EN
      check("timer_lo", in_port, 8'h23);
`else
      check("timer_lo", in_port, 8'h00);
`endif
      step(8'h06, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
`ifdef PICO_IO_TIMER_EN
      check("timer_snap", in_port, 8'h01);
`else
      check("timer_snap", in_port, 8'h00);
`endif

      // Randomized traffic with alternating fill/drain bias
      for (int i = 0; i < 3000; i++) begin
         int          r;
         logic [7:0]  pid, op;
         logic        ws, kws, rs, rxv, fill;
         if (i == 1500) do_reset();
         r    = $urandom_range(0, 9);
         pid  = (r < 8) ? 8'(r) : 8'($urandom);
         op   = 8'($urandom);
         ws   = ($urandom_range(0, 3) == 0);
         kws  = ($urandom_range(0, 3) == 0);
         rs   = ($urandom_range(0, 1) == 1);
         fill = (((i / 200) % 2) == 0);
         rxv  = ($urandom_range(0, 9) < (fill ? 8 : 2));
         if (ws && pid == 8'h04) begin
            if ($urandom_range(0, 3) != 0) op[1] = 1'b0;
            if (op[0]) rxv = 1'b0;
         end
         step(pid, op, ws, kws, rs, rxv, 8'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
